bound_flasher_monitor: RTL
==========================

# bound_flasher_monitor

Passive checker that sits on the 16-bit LED bus driven by the bound flasher. Each cycle it decodes the bar into a lit-lamp level and tracks the expected flasher phase sequence. It flags any illegal bar value or transition and counts completed flash cycles and errors. It drives nothing back into the flasher; it is used in the bench and as an on-chip debug observer.

## Interface
- `MAX_LED`, default 16: LED bus width. Phase targets below are defined for 16 only.
- `CNT_W`, default 8: width of the saturating `done_count` and `err_count` counters.
- `clk`, input, 1: clock. All logic is on the rising edge.
- `rst`, input, 1: reset. One clock; reset is synchronous and active-high.
- `led`, input, MAX_LED: LED bar under observation. Bit 0 is lamp 0.
- `level`, output, 5: lit-lamp count L of the last sampled bar, range 0..16.
- `phase`, output, 3: monitor state, encoded as listed under Operation.
- `err`, output, 1: one-cycle pulse on a detected violation.
- `err_code`, output, 2: cause of the last `err`. 0 = none, 1 = CODE, 2 = STEP. Holds its value until the next `err` or reset.
- `done`, output, 1: one-cycle pulse when a full flash cycle completes.
- `done_count`, output, CNT_W: completed cycles, saturating at all-ones.
- `err_count`, output, CNT_W: errors flagged, saturating at all-ones.

## Operation
- Input stage: `led` is registered into `led_q` every cycle. All checks use `led_q`.
- Decode: the bar is valid only if `led_q == (1<<L)-1` for some L in 0..16, i.e. a thermometer code filled from lamp 0.
  - A valid bar sets L = popcount.
  - An invalid bar is a CODE error, and L holds its previous value.
- `prev_L` register: holds L from the previous valid sample. Reset value 0.
- Phase states, each listed as (encoding, direction d, target T):
  - IDLE (0): L holds at 0.
  - UP1 (1, +1, 6)
  - DN1 (2, −1, 0)
  - UP2 (3, +1, 11)
  - DN2 (4, −1, 5)
  - UP3 (5, +1, 16)
  - DN3 (6, −1, 0)
  - SYNC (7): resynchronising. All checks are suppressed.
- SYNC: on a valid sample with L == 0, go to IDLE. Otherwise stay. No `err` is raised in this state.
- IDLE:
  - L == 0: stay.
  - L == 1: go to UP1.
  - Any other valid L: STEP error.
- Moving phases (UP1..DN3):
  - The sample must satisfy L == prev_L + d. Holds (ΔL = 0), jumps and early reversals are STEP errors.
  - If L == T: advance to the next phase. DN3 reaching 0 goes to IDLE and pulses `done`.
  - Otherwise: stay in the current phase.
- Error priority: CODE over STEP.
- On any error:
  - `err` pulses and `err_code` is updated.
  - `err_count` increments (saturating).
  - `phase` goes to SYNC.
- Counters saturate; they never wrap.
- One full legal cycle is 56 level steps: 6 + 6 + 11 + 6 + 11 + 16.

## Timing
- Latency is 2 edges from the input:
  - `led` is sampled at edge n.
  - `level`, `phase`, `err`, `err_code`, `done` and both counts update at edge n+1.
- `err` and `done` are high for exactly one cycle per event. They are never both high in the same cycle.
- Reset values, applied on the edge where `rst` = 1:
  - `led_q` = 0, `prev_L` = 0, `level` = 0.
  - `phase` = SYNC (7).
  - `err` = 0, `err_code` = 0, `done` = 0, `done_count` = 0, `err_count` = 0.
- Reset mid-cycle: the in-flight phase is discarded. After `rst` drops, the monitor sits in SYNC until the bar reads 0, and no error is raised for the partial sequence.
- A target-reached transition and the next step are on consecutive samples. Example: UP1 at L=6 is followed by a DN1 check expecting L=5 on the next sample.
- `rst` overrides everything in the same cycle, including a pending `err` or `done`.

## Test plan
- Full cycle: reset, hold `led`=0 for 3 cycles, then drive the legal 56-step sequence one step per cycle.
  - Required: `phase` walks 7→0→1→2→3→4→5→6→0.
  - Required: `done` pulses once, 2 edges after the final 0 is sampled.
  - Required: `done_count` = 1, `err` never asserts.
- CODE error: in UP1 at L=3, drive `16'h0005`.
  - Required: `err`=1 and `err_code`=1, 2 edges later.
  - Required: `phase`=7 and `err_count`=1.
  - Required: after `led`=0, `phase` returns to 0.
- STEP error: in UP2, jump from L=3 to L=5 (`16'h001F`). Separately, in UP2 reverse at L=8 to L=7, and hold at L=8 for two samples.
  - Required: each case gives `err_code`=2 and `phase`=7.
- IDLE jump: from IDLE drive `16'h0003`.
  - Required: `err_code`=2.
  - Required: no `err` while in SYNC, even for further garbage values, until `led`=0.
- Reset mid-operation: assert `rst` for 1 cycle during DN2 at L=8, then continue the old sequence.
  - Required: all outputs at reset values and no `err` until the bar reaches 0.
  - Required: the next legal full cycle gives `done_count`=1.
- Saturation: run 257 legal cycles with CNT_W=8.
  - Required: `done_count` stops at 255 and `done` still pulses each cycle.
  - Required: 257 CODE errors leave `err_count` at 255.

Source files
------------

// File: rtl/bound_flasher_monitor.sv
// Passive observer of the bound flasher LED bar. It decodes each sampled bar
// into a lit-lamp level, follows the expected phase sequence, and flags
// illegal bar codes (CODE) and illegal level moves (STEP). It also counts
// completed flash cycles and errors.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   led        - LED bar under observation, bit 0 is lamp 0
//   level      - lit-lamp count of the last valid sample (0..16)
//   phase      - monitor state (0 IDLE, 1..6 UP1..DN3, 7 SYNC)
//   err        - one-cycle pulse on a detected violation
//   err_code   - cause of the last err (0 none, 1 CODE, 2 STEP), sticky
//   done       - one-cycle pulse when a full flash cycle completes
//   done_count - completed cycles, saturating
//   err_count  - flagged errors, saturating
module bound_flasher_monitor #(
    parameter int unsigned MAX_LED = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MAX_LED-1:0] led,
    output logic [4:0]         level,
    output logic [2:0]         phase,
    output logic               err,
    output logic [1:0]         err_code,
    output logic               done,
    output logic [CNT_W-1:0]   done_count,
    output logic [CNT_W-1:0]   err_count
);

    localparam int unsigned LVL_W = 5;
    localparam int unsigned INC_W = MAX_LED + 1;

    localparam logic [1:0] CODE_NONE = 2'd0;
    localparam logic [1:0] CODE_CODE = 2'd1;
    localparam logic [1:0] CODE_STEP = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UP1  = 3'd1,
        ST_DN1  = 3'd2,
        ST_UP2  = 3'd3,
        ST_DN2  = 3'd4,
        ST_UP3  = 3'd5,
        ST_DN3  = 3'd6,
        ST_SYNC = 3'd7
    } phase_e;

    // Level at which each moving phase hands over to the next one.
    function automatic logic [LVL_W-1:0] target_of(input phase_e p);
        case (p)
            ST_UP1:  return LVL_W'(6);
            ST_UP2:  return LVL_W'(11);
            ST_DN2:  return LVL_W'(5);
            ST_UP3:  return LVL_W'(16);
            default: return LVL_W'(0);
        endcase
    endfunction

    function automatic phase_e next_of(input phase_e p);
        case (p)
            ST_UP1:  return ST_DN1;
            ST_DN1:  return ST_UP2;
            ST_UP2:  return ST_DN2;
            ST_DN2:  return ST_UP3;
            ST_UP3:  return ST_DN3;
            default: return ST_IDLE;
        endcase
    endfunction

    function automatic logic is_up(input phase_e p);
        return (p == ST_UP1) || (p == ST_UP2) || (p == ST_UP3);
    endfunction

    logic [MAX_LED-1:0] led_q;
    // Marks led_q as a real sample; the reset value of led_q is not one,
    // otherwise it would drag SYNC into IDLE before the bar actually reads 0.
    logic               led_v;
    phase_e             phase_q;
    phase_e             phase_d;

    logic [INC_W-1:0]   led_inc;
    logic               bar_ok;
    logic [LVL_W-1:0]   bar_lvl;
    logic               step_ok;
    logic [1:0]         fault;

    logic [LVL_W-1:0]   level_d;
    logic               err_d;
    logic [1:0]         code_d;
    logic               done_d;
    logic [CNT_W-1:0]   done_cnt_d;
    logic [CNT_W-1:0]   err_cnt_d;

    assign phase = phase_q;

    // Thermometer check: x & (x+1) is zero only for a run of ones from bit 0.
    always_comb begin
        led_inc = {1'b0, led_q} + INC_W'(1);
        bar_ok  = (({1'b0, led_q} & led_inc) == '0);
        bar_lvl = '0;
        for (int i = 0; i < MAX_LED; i++) begin
            bar_lvl = bar_lvl + LVL_W'(led_q[i]);
        end
    end

    // level always holds the last valid L, so it doubles as prev_L.
    assign step_ok = is_up(phase_q) ? (bar_lvl == level + LVL_W'(1))
                                    : (bar_lvl + LVL_W'(1) == level);

    // Next-state and output logic.
    always_comb begin
        phase_d    = phase_q;
        level_d    = level;
        err_d      = 1'b0;
        code_d     = err_code;
        done_d     = 1'b0;
        done_cnt_d = done_count;
        err_cnt_d  = err_count;
        fault      = CODE_NONE;

        if (led_v) begin
            if (!bar_ok) begin
                if (phase_q != ST_SYNC) begin
                    fault = CODE_CODE;
                end
            end else begin
                level_d = bar_lvl;
                case (phase_q)
                    ST_SYNC: begin
                        if (bar_lvl == '0) begin
                            phase_d = ST_IDLE;
                        end
                    end
                    ST_IDLE: begin
                        if (bar_lvl == LVL_W'(1)) begin
                            phase_d = ST_UP1;
                        end else if (bar_lvl != '0) begin
                            fault = CODE_STEP;
                        end
                    end
                    default: begin
                        if (!step_ok) begin
                            fault = CODE_STEP;
                        end else if (bar_lvl == target_of(phase_q)) begin
                            phase_d = next_of(phase_q);
                            if (phase_q == ST_DN3) begin
                                done_d = 1'b1;
                                if (done_count != '1) begin
                                    done_cnt_d = done_count + CNT_W'(1);
                                end
                            end
                        end
                    end
                endcase
            end

            if (fault != CODE_NONE) begin
                err_d   = 1'b1;
                code_d  = fault;
                phase_d = ST_SYNC;
                if (err_count != '1) begin
                    err_cnt_d = err_count + CNT_W'(1);
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q      <= '0;
            led_v      <= 1'b0;
            phase_q    <= ST_SYNC;
            level      <= '0;
            err        <= 1'b0;
            err_code   <= CODE_NONE;
            done       <= 1'b0;
            done_count <= '0;
            err_count  <= '0;
        end else begin
            led_q      <= led;
            led_v      <= 1'b1;
            phase_q    <= phase_d;
            level      <= level_d;
            err        <= err_d;
            err_code   <= code_d;
            done       <= done_d;
            done_count <= done_cnt_d;
            err_count  <= err_cnt_d;
        end
    end

endmodule
